// File: rtl/counter_bcd_modn.sv
// Two-digit BCD down-counter stage with parametrised modulus (2..100),
// validated parallel load and cascade borrow (tc -> en of the next stage).
// Optional build macro: COUNTER_BCD_MODN_HOLD_EN -- saturate at 00 instead of
// wrapping to MODULUS-1 (tc still asserts at 00 as a "timer expired" flag).
module counter_bcd_modn #(
    parameter int unsigned MODULUS     = 60,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       loadn,
    input  logic       en,
    input  logic [7:0] data,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_ones,
    output logic       tc,
    output logic       zero
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BIN_W   = 8;

    // Highest count (MODULUS-1) and reset value, split into BCD digits.
    localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'((MODULUS - 1) / 10);
    localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'((MODULUS - 1) % 10);
    localparam logic [DIGIT_W-1:0] RST_TENS = DIGIT_W'(RESET_VALUE / 10);
    localparam logic [DIGIT_W-1:0] RST_ONES = DIGIT_W'(RESET_VALUE % 10);
    localparam logic [BIN_W-1:0]   MOD_BIN  = BIN_W'(MODULUS);
    localparam logic [DIGIT_W-1:0] NINE     = DIGIT_W'(9);

    // Reject illegal configurations at elaboration.
    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
        $error("counter_bcd_modn: MODULUS must be in 2..100");
    end
    if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
        $error("counter_bcd_modn: RESET_VALUE must be below MODULUS");
    end

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic [BIN_W-1:0]   load_bin;
    logic               load_ok;
    logic               digits_bad;

    // Load validation: both nibbles decimal and value inside the modulus range.
    always_comb begin
        load_bin = BIN_W'(data[7:4]) * BIN_W'(10) + BIN_W'(data[3:0]);
        load_ok  = (data[7:4] <= NINE) && (data[3:0] <= NINE) && (load_bin < MOD_BIN);
    end

    // Non-decimal digits can only appear if forced; next count recovers to MODULUS-1.
    always_comb begin
        digits_bad = (tens_q > NINE) || (ones_q > NINE);
    end

    // Next-count selection: load > count > hold (reset handled in the register).
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (!loadn) begin
            if (load_ok) begin
                tens_d = data[7:4];
                ones_d = data[3:0];
            end else begin
                tens_d = MAX_TENS;
                ones_d = MAX_ONES;
            end
        end else if (en) begin
            if (digits_bad) begin
                tens_d = MAX_TENS;
                ones_d = MAX_ONES;
            end else if (ones_q != '0) begin
                ones_d = ones_q - DIGIT_W'(1);
            end else if (tens_q != '0) begin
                ones_d = NINE;
                tens_d = tens_q - DIGIT_W'(1);
            end else begin
`ifdef COUNTER_BCD_MODN_HOLD_EN
                tens_d = tens_q;
                ones_d = ones_q;
`else
                tens_d = MAX_TENS;
                ones_d = MAX_ONES;
`endif
            end
        end
    end

    // Digit registers with asynchronous reset to RESET_VALUE.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            tens_q <= RST_TENS;
            ones_q <= RST_ONES;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    // Registered digits out; zero and borrow follow them combinationally.
    always_comb begin
        digit_tens = tens_q;
        digit_ones = ones_q;
        zero       = (tens_q == '0) && (ones_q == '0);
        tc         = en & loadn & zero;
    end

endmodule

// File: tb/tb_counter_bcd_modn.sv
// Bench for counter_bcd_modn: seconds (mod 60) cascaded into minutes (mod 100),
// plus an independent mod-7 stage with a non-zero reset value.
module tb_counter_bcd_modn;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       clearn;
    logic       ld60_n, en60, ld100_n, ld7_n, en7;
    logic [7:0] d60, d100, d7;
    logic [3:0] t60, o60, t100, o100, t7, o7;
    logic       tc60, z60, tc100, z100, tc7, z7;

    counter_bcd_modn #(.MODULUS(60), .RESET_VALUE(0)) u_sec (
        .clock(clock), .clearn(clearn), .loadn(ld60_n), .en(en60), .data(d60),
        .digit_tens(t60), .digit_ones(o60), .tc(tc60), .zero(z60));

    counter_bcd_modn #(.MODULUS(100), .RESET_VALUE(0)) u_min (
        .clock(clock), .clearn(clearn), .loadn(ld100_n), .en(tc60), .data(d100),
        .digit_tens(t100), .digit_ones(o100), .tc(tc100), .zero(z100));

    counter_bcd_modn #(.MODULUS(7), .RESET_VALUE(3)) u_m7 (
        .clock(clock), .clearn(clearn), .loadn(ld7_n), .en(en7), .data(d7),
        .digit_tens(t7), .digit_ones(o7), .tc(tc7), .zero(z7));

    typedef struct {
        logic       clearn;
        logic       ld60_n;
        logic [7:0] d60;
        logic       en60;
        logic       ld100_n;
        logic [7:0] d100;
        logic       ld7_n;
        logic [7:0] d7;
        logic       en7;
    } stim_t;

    // Expected pre-edge flags (index 0=sec,1=min,2=mod7) and post-edge counts.
    typedef struct {
        logic [2:0] tc;
        logic [2:0] zero;
        int         v60;
        int         v100;
        int         v7;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference counts held as plain integers.
    int c60  = 0;
    int c100 = 0;
    int c7   = 3;

    function automatic int load_val(input int m, input logic [7:0] d);
        int t;
        int o;
        t = int'(d[7:4]);
        o = int'(d[3:0]);
        if (t <= 9 && o <= 9 && (10 * t + o) < m) return 10 * t + o;
        return m - 1;
    endfunction

    function automatic int count_val(input int m, input int c);
        if (c > 0) return c - 1;
`ifdef COUNTER_BCD_MODN_HOLD_EN
        return 0;
`else
        return m - 1;
`endif
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.clearn = 1'b1; s.ld60_n = 1'b1; s.d60 = 8'h00; s.en60 = 1'b0;
        s.ld100_n = 1'b1; s.d100 = 8'h00; s.ld7_n = 1'b1; s.d7 = 8'h00; s.en7 = 1'b0;
        return s;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expected response.
    task automatic step(input stim_t s);
        exp_t e;
        logic b60;
        logic b100;
        logic b7;
        @(negedge clock);
        clearn = s.clearn; ld60_n = s.ld60_n; d60 = s.d60; en60 = s.en60;
        ld100_n = s.ld100_n; d100 = s.d100; ld7_n = s.ld7_n; d7 = s.d7; en7 = s.en7;
        if (!s.clearn) begin
            c60 = 0; c100 = 0; c7 = 3;
        end
        b60  = s.en60 & s.ld60_n & (c60 == 0);
        b100 = b60 & s.ld100_n & (c100 == 0);
        b7   = s.en7 & s.ld7_n & (c7 == 0);
        e.tc   = {b7, b100, b60};
        e.zero = {(c7 == 0), (c100 == 0), (c60 == 0)};
        if (s.clearn) begin
            if (!s.ld100_n)  c100 = load_val(100, s.d100);
            else if (b60)    c100 = count_val(100, c100);
            if (!s.ld60_n)   c60 = load_val(60, s.d60);
            else if (s.en60) c60 = count_val(60, c60);
            if (!s.ld7_n)    c7 = load_val(7, s.d7);
            else if (s.en7)  c7 = count_val(7, c7);
        end
        e.v60 = c60; e.v100 = c100; e.v7 = c7;
        #1;
        q.push_back(e);
    endtask

    // Monitor: flags checked before the edge, counts checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (q.size() > 0) begin
                e = q[0];
                chk("tc_sec",    {7'd0, tc60},  {7'd0, e.tc[0]});
                chk("tc_min",    {7'd0, tc100}, {7'd0, e.tc[1]});
                chk("tc_mod7",   {7'd0, tc7},   {7'd0, e.tc[2]});
                chk("zero_sec",  {7'd0, z60},   {7'd0, e.zero[0]});
                chk("zero_min",  {7'd0, z100},  {7'd0, e.zero[1]});
                chk("zero_mod7", {7'd0, z7},    {7'd0, e.zero[2]});
                @(posedge clock);
                #1;
                void'(q.pop_front());
                chk("count_sec",  {t60, o60},   bcd(e.v60));
                chk("count_min",  {t100, o100}, bcd(e.v100));
                chk("count_mod7", {t7, o7},     bcd(e.v7));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        logic [7:0] clamp_sec[4];
        logic [7:0] clamp_min[4];
        clamp_sec[0] = 8'h60; clamp_sec[1] = 8'h0A; clamp_sec[2] = 8'h99; clamp_sec[3] = 8'h7A;
        clamp_min[0] = 8'h99; clamp_min[1] = 8'hA0; clamp_min[2] = 8'h0F; clamp_min[3] = 8'h42;

        clearn = 1'b0; ld60_n = 1'b1; en60 = 1'b0; d60 = '0;
        ld100_n = 1'b1; d100 = '0; ld7_n = 1'b1; en7 = 1'b0; d7 = '0;

        // Reset held two cycles.
        s = idle(); s.clearn = 1'b0;
        step(s); step(s);

        // Loads: 25 into seconds, 05 into minutes, 07 clamps to 06 on mod 7.
        s = idle(); s.ld60_n = 1'b0; s.d60 = 8'h25; s.ld100_n = 1'b0; s.d100 = 8'h05;
        s.ld7_n = 1'b0; s.d7 = 8'h07;
        step(s);

        // Countdown through the wrap with borrow into minutes.
        s = idle(); s.ld60_n = 1'b0; s.d60 = 8'h02;
        step(s);
        s = idle(); s.en60 = 1'b1;
        repeat (4) step(s);

        // Clamp of illegal load values.
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.ld60_n = 1'b0; s.d60 = clamp_sec[i];
            s.ld100_n = 1'b0; s.d100 = clamp_min[i];
            step(s);
        end

        // Load dominates enable, and masks tc even at 00.
        s = idle(); s.ld60_n = 1'b0; s.d60 = 8'h00;
        step(s);
        s = idle(); s.ld60_n = 1'b0; s.en60 = 1'b1; s.d60 = 8'h10;
        step(s);

        // Asynchronous reset mid-cycle while counting.
        s = idle(); s.en60 = 1'b1;
        step(s);
        @(negedge clock);
        #2;
        clearn = 1'b0;
        #1;
        chk("async_sec",  {t60, o60},   8'h00);
        chk("async_min",  {t100, o100}, 8'h00);
        chk("async_mod7", {t7, o7},     8'h03);
        c60 = 0; c100 = 0; c7 = 3;
        s = idle(); s.clearn = 1'b0; s.en60 = 1'b1;
        step(s);
        s = idle(); s.en60 = 1'b1;
        step(s);

        // Cascade 01:00 -> 00:59.
        s = idle(); s.ld60_n = 1'b0; s.d60 = 8'h00; s.ld100_n = 1'b0; s.d100 = 8'h01;
        step(s);
        s = idle(); s.en60 = 1'b1;
        step(s);
        s = idle();
        step(s);

        // Mod-7 wrap from 00 to 06.
        s = idle(); s.ld7_n = 1'b0; s.d7 = 8'h00;
        step(s);
        s = idle(); s.en7 = 1'b1;
        step(s); step(s);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.clearn  = ($urandom_range(0, 39) != 0);
            s.ld60_n  = ($urandom_range(0, 7) != 0);
            s.ld100_n = ($urandom_range(0, 7) != 0);
            s.ld7_n   = ($urandom_range(0, 7) != 0);
            s.en60    = ($urandom_range(0, 3) != 0);
            s.en7     = ($urandom_range(0, 3) != 0);
            s.d60  = $urandom_range(0, 1) ? 8'($urandom) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            s.d100 = $urandom_range(0, 1) ? 8'($urandom) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            s.d7   = $urandom_range(0, 1) ? 8'($urandom) : {4'h0, 4'($urandom_range(0, 9))};
            step(s);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        #2;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_bcd_modn.md
Name: counter_bcd_modn

Overview:
- Two-digit BCD down-counter with a parametrised modulus (2..100) for the minutes/seconds timer chain.
- Generalises the single-digit mod-6 stage: one instance covers a full seconds field (MODULUS=60) or minutes field (MODULUS=100).
- Adds validated parallel load and a cascade borrow (tc).
- Instances chain tc -> en of the next, more significant stage.

Parameters:
- MODULUS, 60, count range 00..MODULUS-1; legal 2..100, elaboration error ($error in generate) otherwise.
- RESET_VALUE, 0, binary value loaded by clearn; must be < MODULUS.

Ports:
- clock  input  1  rising-edge clock.
- clearn  input  1  asynchronous active-low reset.
- loadn  input  1  synchronous active-low parallel load.
- en  input  1  count-down enable (borrow in from the less significant stage).
- data  input  8  load value; [7:4] tens BCD, [3:0] ones BCD.
- digit_tens  output  4  tens BCD digit, registered.
- digit_ones  output  4  ones BCD digit, registered.
- tc  output  1  terminal count / borrow out, combinational.
- zero  output  1  count == 00, combinational.

Behaviour:
- Reset: clearn low forces digit_tens/digit_ones to the BCD of RESET_VALUE immediately, without waiting for clock. Default 00, so zero=1.
  - Reset dominates loadn and en.
  - Release is sampled at the next rising edge; no count on the release edge unless en is already high.
- Priority at each rising edge: clearn low > loadn low > en high > hold.
- Load (loadn=0):
  - Next count = data if both nibbles are <= 9 and the value (10*tens + ones) < MODULUS.
  - Otherwise next count = MODULUS-1 (clamp). Example: MODULUS=60, data=8'h7A loads 59.
  - Load ignores en; tc is forced 0 while loadn=0.
- Count (loadn=1, en=1):
  - digit_ones > 0: ones decrements.
  - digit_ones = 0 and tens > 0: ones becomes 9, tens decrements.
  - Count = 00: wraps to MODULUS-1. For MODULUS=60 the next value is 59; for MODULUS=100 it is 99; for MODULUS=7 it is 06.
- Hold (en=0): count is unchanged.
- tc = en & loadn & zero. It is high for exactly the cycle in which the stage wraps, so the next stage decrements on that same edge.
- zero = (digit_tens==0 && digit_ones==0), independent of en.
- Latency:
  - Load and count both take effect at the first rising edge after the condition.
  - tc/zero follow the registered count combinationally, with zero-cycle latency on en.
- Internal state is held only as two BCD digits, with no binary shadow register. Digit values above 9 are unreachable; if forced, the next count edge loads MODULUS-1.
- Reset mid-count or mid-load: the count is lost and RESET_VALUE applies. No pending operation survives reset.

Optional Feature:
- Macro: COUNTER_BCD_MODN_HOLD_EN.
- Defined: the stage saturates at 00 instead of wrapping.
  - An en at 00 leaves the count at 00.
  - tc still asserts for that cycle, used as "timer expired" on the most significant stage.
  - Load behaviour is unchanged.
- Undefined: wrap-around to MODULUS-1 as specified above.

Test Plan:
- Reset/load: clearn=0 for 2 cycles -> 00, zero=1, tc=0. Then loadn=0 with data=8'h25 (MODULUS=60) -> 25 after one edge, zero=0.
- Countdown and borrow: load 8'h02, en=1 for 4 edges -> 02, 01, 00, 59, 58. tc=1 only in the cycle at 00 with en=1.
- Clamp: MODULUS=60 with data=8'h60, 8'h0A and 8'h99 -> each loads 59. MODULUS=100 with data=8'h99 -> loads 99.
- Priority and async reset: loadn=0 and en=1 together with data=8'h10 -> 10, tc=0. Then clearn pulsed low mid-cycle while en=1 -> outputs go to 00 before the next edge.
- Cascade: seconds (MODULUS=60) tc drives minutes (MODULUS=100) en. Load 01:00, seconds en=1 -> 00:59 on the first edge; minutes zero=1 afterwards.
- HOLD_EN build: load 8'h01, en=1 for 3 edges -> 00, 00, 00. tc=1 on the 2nd and 3rd cycles. Without the macro, the same stimulus yields 00, 59, 58.
